// File: rtl/tpgc.sv
// tpgc: test pattern generator for the 5-bit ripple-carry adder datapath.
// Presents eight fixed carry-chain patterns, then an endless generator sweep.
// Optional build macro: TPGC_LFSR_EN selects an 11-bit LFSR generator
// (x^11+x^9+1, period 2047); without it an 11-bit up-counter sweeps all
// 2048 {a,b,c_1} combinations.
module tpgc (
  input  logic       clk,
  input  logic       init,
  output logic [4:0] a,
  output logic [4:0] b,
  output logic       c_1
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned ST_W  = 11;
  localparam int unsigned IDX_W = 3;

`ifdef TPGC_LFSR_EN
  localparam logic [ST_W-1:0] S_START = 11'h001;
`else
  localparam logic [ST_W-1:0] S_START = 11'h000;
`endif

  typedef enum logic {
    ST_GEN = 1'b0,
    ST_DET = 1'b1
  } phase_t;

  phase_t             state;
  phase_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [ST_W-1:0]    s;
  logic [ST_W-1:0]    s_nxt;
  logic [ST_W-1:0]    pat_nxt;

  // Generator successor function for the selected build.
  function automatic logic [ST_W-1:0] gen_next(input logic [ST_W-1:0] cur);
`ifdef TPGC_LFSR_EN
    return {cur[9:0], cur[10] ^ cur[8]};
`else
    return cur + ST_W'(1);
`endif
  endfunction

  // Fixed carry-chain patterns, packed as {a, b, c_1}.
  function automatic logic [ST_W-1:0] det_pat(input logic [IDX_W-1:0] i);
    logic [ST_W-1:0] p;
    case (i)
      3'd0:    p = {5'b00000, 5'b00000, 1'b0};
      3'd1:    p = {5'b11111, 5'b11111, 1'b1};
      3'd2:    p = {5'b11111, 5'b00000, 1'b1};
      3'd3:    p = {5'b00000, 5'b11111, 1'b1};
      3'd4:    p = {5'b10101, 5'b01010, 1'b0};
      3'd5:    p = {5'b01010, 5'b10101, 1'b1};
      3'd6:    p = {5'b11111, 5'b00001, 1'b0};
      default: p = {5'b00001, 5'b11111, 1'b0};
    endcase
    return p;
  endfunction

  // Next phase, index, generator state and output pattern.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    s_nxt     = s;
    pat_nxt   = {a, b, c_1};
    if (state == ST_DET) begin
      idx_nxt = idx + IDX_W'(1);
      if (idx == IDX_W'(7)) begin
        state_nxt = ST_GEN;
        s_nxt     = S_START;
        pat_nxt   = S_START;
      end else begin
        pat_nxt = det_pat(idx_nxt);
      end
    end else begin
      s_nxt   = gen_next(s);
      pat_nxt = s_nxt;
    end
  end

  // State and output registers; init low forces pattern 0.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state <= ST_DET;
      idx   <= '0;
      s     <= '0;
      a     <= '0;
      b     <= '0;
      c_1   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      s     <= s_nxt;
      a     <= pat_nxt[ST_W-1 -: OP_W];
      b     <= pat_nxt[OP_W:1];
      c_1   <= pat_nxt[0];
    end
  end

endmodule

// File: tb/tb_tpgc.sv
// Directed testbench for tpgc; honours TPGC_LFSR_EN like the design.
module tb_tpgc;

  logic       clk = 1'b0;
  logic       init;
  logic [4:0] a;
  logic [4:0] b;
  logic       c_1;

  int tests = 0;
  int fails = 0;

`ifdef TPGC_LFSR_EN
  localparam logic [10:0] START = 11'h001;
`else
  localparam logic [10:0] START = 11'h000;
`endif

  tpgc dut (
    .clk (clk),
    .init(init),
    .a   (a),
    .b   (b),
    .c_1 (c_1)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {a, b, c_1};
  endfunction

  // Hand-written deterministic table, {a,b,c_1}.
  function automatic logic [10:0] det_exp(input int n);
    logic [10:0] p;
    case (n)
      0:       p = 11'b00000_00000_0;
      1:       p = 11'b11111_11111_1;
      2:       p = 11'b11111_00000_1;
      3:       p = 11'b00000_11111_1;
      4:       p = 11'b10101_01010_0;
      5:       p = 11'b01010_10101_1;
      6:       p = 11'b11111_00001_0;
      default: p = 11'b00001_11111_0;
    endcase
    return p;
  endfunction

  function automatic logic [10:0] gen_exp_next(input logic [10:0] cur);
`ifdef TPGC_LFSR_EN
    return {cur[9:0], cur[10] ^ cur[8]};
`else
    return cur + 11'd1;
`endif
  endfunction

  // One rising edge, then settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    init = 1'b1;
    #2;
    init = 1'b0;
    #1;
    tests++;
    if (obs() !== 11'h000) begin
      fails++;
      $display("FAIL reset_async got=%h exp=%h", obs(), 11'h000);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (obs() !== 11'h000) begin
        fails++;
        $display("FAIL reset_hold%0d got=%h exp=%h", i, obs(), 11'h000);
      end
    end
    init = 1'b1;
  endtask

  task automatic test_deterministic(input string tag);
    for (int n = 1; n <= 7; n++) begin
      step();
      tests++;
      if (obs() !== det_exp(n)) begin
        fails++;
        $display("FAIL %s_det%0d got=%b exp=%b", tag, n, obs(), det_exp(n));
      end
    end
  endtask

  task automatic test_generator();
    logic [10:0] exp_s;
    logic [10:0] cur;
    bit          seen [2048];
    int          uniq;
    int          last_k;
    int          bad;
`ifdef TPGC_LFSR_EN
    last_k = 2047;
`else
    last_k = 2048;
`endif
    foreach (seen[i]) seen[i] = 1'b0;
    uniq  = 0;
    bad   = 0;
    exp_s = START;
    for (int k = 0; k <= last_k; k++) begin
      step();
      cur = obs();
      if (cur !== exp_s) bad++;
      if (k < 2047 && !seen[cur]) begin
        seen[cur] = 1'b1;
        uniq++;
      end
      // Hand-computed anchors at the start and wrap of the sweep.
`ifdef TPGC_LFSR_EN
      if (k == 0 || k == 1 || k == 2 || k == 2047) begin
        logic [10:0] anchor;
        anchor = (k == 0) ? 11'b00000_00000_1 :
                 (k == 1) ? 11'b00000_00001_0 :
                 (k == 2) ? 11'b00000_00010_0 : 11'h001;
        tests++;
        if (cur !== anchor) begin
          fails++;
          $display("FAIL gen_edge%0d got=%b exp=%b", k + 8, cur, anchor);
        end
      end
`else
      if (k == 0 || k == 1 || k == 2047 || k == 2048) begin
        logic [10:0] anchor;
        anchor = (k == 0) ? 11'b00000_00000_0 :
                 (k == 1) ? 11'b00000_00000_1 :
                 (k == 2047) ? 11'b11111_11111_1 : 11'h000;
        tests++;
        if (cur !== anchor) begin
          fails++;
          $display("FAIL gen_edge%0d got=%b exp=%b", k + 8, cur, anchor);
        end
      end
`endif
      exp_s = gen_exp_next(exp_s);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL gen_sequence mismatches got=%0d exp=0", bad);
    end
`ifdef TPGC_LFSR_EN
    tests++;
    if (uniq != 2047 || seen[0]) begin
      fails++;
      $display("FAIL lfsr_period unique got=%0d exp=2047 zero_seen=%0d", uniq, seen[0]);
    end
`else
    tests++;
    if (uniq != 2047) begin
      fails++;
      $display("FAIL counter_sweep unique got=%0d exp=2047", uniq);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp_s;
    init = 1'b0;
    step();
    init = 1'b1;
    exp_s = START;
    repeat (8) step();
    for (int k = 1; k <= 100; k++) begin
      step();
      exp_s = gen_exp_next(exp_s);
    end
    tests++;
    if (obs() !== exp_s) begin
      fails++;
      $display("FAIL mid_gen100 got=%h exp=%h", obs(), exp_s);
    end
    #2;
    init = 1'b0;
    #1;
    tests++;
    if (obs() !== 11'h000) begin
      fails++;
      $display("FAIL mid_async got=%h exp=%h", obs(), 11'h000);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (obs() !== 11'h000) begin
        fails++;
        $display("FAIL mid_hold%0d got=%h exp=%h", i, obs(), 11'h000);
      end
    end
    init = 1'b1;
    test_deterministic("mid");
    step();
    tests++;
    if (obs() !== START) begin
      fails++;
      $display("FAIL mid_gen_start got=%h exp=%h", obs(), START);
    end
  endtask

  initial begin
    init = 1'b1;
    test_reset();
    test_deterministic("first");
    test_generator();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
